// File: rtl/adder_share_arb_pkg.sv
// Shared constants for the adder_share_arb arbiter: default width, FSM encodings, requester indices.
package adder_share_arb_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_share_arb_adder_core.sv
// Purely combinational WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
module adder_core
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_share_arb.sv
// Two-requester round-robin arbiter sequencing one shared ripple-carry adder (grant, then result).
// Optional signed-overflow output enabled by defining ADDER_ARB_OVF_EN.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             vld0,
    output logic             vld1,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_ARB_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ptr;
    logic             ptr_nxt;
    logic             owner;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

    logic             elig0;
    logic             elig1;
    logic             win_vld;
    logic             win_idx;
    logic [WIDTH-1:0] op_a_nxt;
    logic [WIDTH-1:0] op_b_nxt;
    logic             op_cin_nxt;
    logic             gnt0_nxt;
    logic             gnt1_nxt;
    logic             vld0_nxt;
    logic             vld1_nxt;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    adder_core #(.WIDTH(WIDTH)) u_adder_core (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Arbitration and next-state; a requester is ineligible while its grant is still visible.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        win_idx    = REQ0;
        op_a_nxt   = op_a;
        op_b_nxt   = op_b;
        op_cin_nxt = op_cin;

        elig0   = req0 & ~gnt0;
        elig1   = req1 & ~gnt1;
        win_vld = elig0 | elig1;

        if (elig0 && elig1) begin
            win_idx = ptr;
            ptr_nxt = ~ptr;
        end else if (elig1) begin
            win_idx = REQ1;
        end

        if (win_vld) begin
            op_a_nxt   = (win_idx == REQ1) ? a1 : a0;
            op_b_nxt   = (win_idx == REQ1) ? b1 : b0;
            op_cin_nxt = (win_idx == REQ1) ? cin1 : cin0;
        end

        gnt0_nxt = win_vld && (win_idx == REQ0);
        gnt1_nxt = win_vld && (win_idx == REQ1);
        vld0_nxt = (state == GRANT) && (owner == REQ0);
        vld1_nxt = (state == GRANT) && (owner == REQ1);

        case (state)
            IDLE:    state_nxt = win_vld ? GRANT : IDLE;
            GRANT:   state_nxt = win_vld ? GRANT : RESULT;
            RESULT:  state_nxt = win_vld ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= REQ0;
            owner  <= REQ0;
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            vld0   <= 1'b0;
            vld1   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            op_a   <= op_a_nxt;
            op_b   <= op_b_nxt;
            op_cin <= op_cin_nxt;
            gnt0   <= gnt0_nxt;
            gnt1   <= gnt1_nxt;
            vld0   <= vld0_nxt;
            vld1   <= vld1_nxt;
            if (win_vld) begin
                owner <= win_idx;
            end
            // Result stage: capture the adder while the granted op is in flight.
            if (state == GRANT) begin
                sum  <= add_sum;
                cout <= add_cout;
`ifdef ADDER_ARB_OVF_EN
                ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb (define ADDER_ARB_OVF_EN to also check ovf).
module tb_adder_share_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, cin0, cin1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, vld0, vld1, cout;
    logic [3:0] sum;
`ifdef ADDER_ARB_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_share_arb #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .a0   (a0),
        .b0   (b0),
        .cin0 (cin0),
        .req1 (req1),
        .a1   (a1),
        .b1   (b1),
        .cin1 (cin1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .vld0 (vld0),
        .vld1 (vld1),
        .sum  (sum),
`ifdef ADDER_ARB_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake outputs packed as {gnt0,gnt1,vld0,vld1}.
    task automatic chk_hs(input string tag, input logic [3:0] exp);
        chk(tag, 8'({gnt0, gnt1, vld0, vld1}), 8'(exp));
    endtask

    task automatic chk_res(input string tag, input logic [3:0] s, input logic c);
        chk({tag, "_sum"}, 8'(sum), 8'(s));
        chk({tag, "_cout"}, 8'(cout), 8'(c));
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b1; a0 = 4'h3; b0 = 4'h5; cin0 = 1'b0;
        req1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1;

        // Reset held with both requesting.
        tick(); tick(); tick();
        chk_hs("reset_hs", 4'b0000);
        chk_res("reset", 4'h0, 1'b0);

        // Release: contention, requester 0 wins first.
        rst = 1'b0;
        tick();
        chk_hs("first_gnt0", 4'b1000);
        a0 = 4'h6; b0 = 4'h7; cin0 = 1'b1;

        tick();
        chk_hs("alt_gnt1", 4'b0101 & 4'b0100 | 4'b0010);
        chk_res("op0_3p5", 4'h8, 1'b0);
        a1 = 4'h2; b1 = 4'h3; cin1 = 1'b0;

        tick();
        chk_hs("alt_gnt0", 4'b1001);
        chk_res("op1_wrap", 4'h1, 1'b1);

        tick();
        chk_hs("alt_gnt1_b", 4'b0110);
        chk_res("op0_6p7c", 4'hE, 1'b0);
        req0 = 1'b0; req1 = 1'b0;

        tick();
        chk_hs("drain_vld1", 4'b0001);
        chk_res("op1_2p3", 4'h5, 1'b0);

        tick();
        chk_hs("idle", 4'b0000);
        chk_res("hold", 4'h5, 1'b0);

        // Mid-op reset: pointer currently favours requester 1.
        req0 = 1'b1; a0 = 4'h7; b0 = 4'h1; cin0 = 1'b0;
        tick();
        chk_hs("pre_rst_gnt0", 4'b1000);
        rst = 1'b1; req0 = 1'b0;
        tick();
        chk_hs("midrst_hs", 4'b0000);
        chk_res("midrst", 4'h0, 1'b0);
        rst = 1'b0;
        tick();
        chk_hs("post_rst_novld", 4'b0000);

        // Contention after reset goes to requester 0 again.
        req0 = 1'b1; a0 = 4'h7; b0 = 4'h1; cin0 = 1'b0;
        req1 = 1'b1; a1 = 4'h8; b1 = 4'h8; cin1 = 1'b0;
        tick();
        chk_hs("post_rst_gnt0", 4'b1000);
        tick();
        chk_hs("post_rst_gnt1", 4'b0110);
        chk_res("op0_7p1", 4'h8, 1'b0);
`ifdef ADDER_ARB_OVF_EN
        chk("ovf_7p1", 8'(ovf), 8'h1);
`endif
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk_hs("op1_vld", 4'b0001);
        chk_res("op1_8p8", 4'h0, 1'b1);
`ifdef ADDER_ARB_OVF_EN
        chk("ovf_8p8", 8'(ovf), 8'h1);
`endif

        // Single requester held: one grant every other cycle.
        req0 = 1'b1; a0 = 4'h1; b0 = 4'h1; cin0 = 1'b0;
        tick();
        chk_hs("solo_gnt_a", 4'b1000);
        tick();
        chk_hs("solo_gap", 4'b0010);
        chk_res("solo_1p1", 4'h2, 1'b0);
        tick();
        chk_hs("solo_gnt_b", 4'b1000);
        req0 = 1'b0;
        tick();
        chk_hs("solo_vld_b", 4'b0010);
        tick();
        chk_hs("final_idle", 4'b0000);
        chk_res("final_hold", 4'h2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Mutual exclusion of grants and of valids, checked every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(gnt0 && gnt1) && !(vld0 && vld1)) else begin
                errors++;
                $error("FAIL excl observed=%0b expected=no_overlap", {gnt0, gnt1, vld0, vld1});
            end
        end
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared WIDTH-bit ripple-carry adder.
- Each requester holds a request and its operands until granted. It then receives a one-cycle grant pulse, followed one cycle later by a registered sum/carry result and a valid pulse.
- Sits between client datapath blocks and the single adder instance, so the adder is never duplicated.

Parameters:
- WIDTH, 4, operand and sum width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 wants an add
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- cin0  input  1  requester 0 carry-in
- req1  input  1  requester 1 wants an add
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- cin1  input  1  requester 1 carry-in
- gnt0  output  1  one-cycle grant pulse to requester 0
- gnt1  output  1  one-cycle grant pulse to requester 1
- vld0  output  1  one-cycle result-valid pulse to requester 0
- vld1  output  1  one-cycle result-valid pulse to requester 1
- sum  output  WIDTH  registered adder sum, shared by both requesters
- cout  output  1  registered adder carry-out

Behaviour:
- Reset: on clk edge with rst=1, the following are all 0: gnt0, gnt1, vld0, vld1, sum, cout, operand registers and the FSM. The priority pointer resets to favour requester 0. Reset mid-operation discards any in-flight op; no vld is issued for it.
- Eligibility: reqN is eligible at an edge only if gntN is not currently high. The requester sees its own grant one cycle late, so this prevents double-issue.
- Arbitration at each edge:
  - Only one eligible requester: that requester wins.
  - Both eligible: the requester pointed to by the priority pointer wins, and the pointer flips to the loser.
  - Neither eligible: no grant.
- Winner capture: the winner's a, b and cin are latched into operand registers, and gntN=1 for exactly the next cycle. An owner tag holds the winner's index.
- Execute: during the grant cycle the adder computes combinationally from the operand registers. At the next edge, sum/cout are registered and vldN (N = owner tag) is pulsed for one cycle.
- Latency: req sampled at edge k → gnt during cycle k+1 → vld, sum and cout during cycle k+2.
- Throughput: one op per cycle when both requesters alternate; a single requester gets one op every 2 cycles.
- Hold after result: sum/cout keep their last value until the next result; they are meaningful only while the matching vld is high.
- FSM per issue slot: IDLE → GRANT (operands latched, gnt high) → RESULT (vld high).
  - GRANT and RESULT overlap across back-to-back ops, giving a two-stage pipeline.
  - RESULT → GRANT occurs directly when a new winner is pending; otherwise RESULT → IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned ripple.
- Requester rules: reqN with stable operands must be held until gntN is seen, then deasserted or a new op presented. Operand changes before the grant are legal; the values sampled at the winning edge are used.
- Simultaneous events: a new grant and a previous result in the same cycle is normal pipelined operation. gnt0 and gnt1 are never high together; the same holds for vld0 and vld1.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- Defined: adds output port ovf (1 bit), registered alongside sum. ovf = signed two's-complement overflow, i.e. (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). ovf resets to 0.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package/header:
  - WIDTH default.
  - FSM state encodings IDLE=2'd0, GRANT=2'd1, RESULT=2'd2.
  - Requester index constants REQ0=1'b0, REQ1=1'b1.
- Natural sub-module: adder_core. It is a parameterised WIDTH-bit ripple-carry adder built from 1-bit full-adder cells (sum = a^b^c, carry = majority). It is purely combinational and is instantiated once.

Test Plan:
- Reset: hold rst=1 with req0=req1=1 for 3 cycles → all outputs 0 and no gnt. Release → gnt0 first.
- Single op: req0=1, a0=4'h3, b0=4'h5, cin0=0 at edge k → gnt0 in cycle k+1; vld0=1 with sum=4'h8, cout=0 in cycle k+2.
- Carry-out and wrap: req1 with a1=4'hF, b1=4'h1, cin1=1 → vld1 with sum=4'h1, cout=1.
- Contention/fairness: both held continuously → grants alternate gnt0, gnt1, gnt0, gnt1 on consecutive cycles. Each vld matches its own operands, and no cycle has two grants.
- Mid-op reset: rst=1 during a grant cycle → no vld afterwards, sum=0. The next contended grant goes to requester 0.
- Overflow (ADDER_ARB_OVF_EN defined): a0=4'h7, b0=4'h1, cin0=0 → sum=4'h8, ovf=1. With a0=4'h8, b0=4'h8 → sum=4'h0, cout=1, ovf=1.
